// File: rtl/mdu_hilo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : mdu_hilo_pkg                                                   |
// | Purpose : Shared definitions for the multiply/divide unit: op encodings  |
// |           (also used by the decoder and hazard unit), default busy       |
// |           cycle counts and FSM state encodings.                          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package mdu_hilo_pkg;

   // Op encodings. Bit 1 selects divide, bit 0 selects unsigned.
   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   // Default busy cycle counts.
   localparam int MDU_MULT_CYCLES_DEF = 5;
   localparam int MDU_DIV_CYCLES_DEF  = 10;

   // FSM states.
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage : mdu_hilo_pkg
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mdu_arith                                                      |
// | Purpose : Combinational 32x32 multiply and divide for mdu_hilo.          |
// |           Produces the HI/LO pair for the selected op and a write        |
// |           enable that is low for a divide by zero (HI/LO untouched).     |
// | Ports   : op_i      [1:0]  operation (MDU_MULT/MULTU/DIV/DIVU)           |
// |           a_i       [31:0] rs operand (multiplicand / dividend)          |
// |           b_i       [31:0] rt operand (multiplier / divisor)             |
// |           res_hi_o  [31:0] product high word / remainder                 |
// |           res_lo_o  [31:0] product low word / quotient                   |
// |           wr_en_o          result should be committed to HI/LO          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mdu_arith
   import mdu_hilo_pkg::*;
(
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] res_hi_o,
   output logic [31:0] res_lo_o,
   output logic        wr_en_o
);

   logic        w_is_div;
   logic        w_signed;
   logic [63:0] w_prod;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_divisor;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_is_div = op_is_div(op_i);
   assign w_signed = ~op_i[0];

   // Sign- or zero-extend to 64 bits so one unsigned multiplier yields the
   // correct low 64 bits for both MULT and MULTU.
   always_comb begin
      logic [63:0] ext_a;
      logic [63:0] ext_b;
      ext_a  = {{32{w_signed & a_i[31]}}, a_i};
      ext_b  = {{32{w_signed & b_i[31]}}, b_i};
      w_prod = ext_a * ext_b;
   end

   // Signed divide works on magnitudes and fixes signs afterwards. The
   // magnitude of 0x80000000 is 0x80000000 as an unsigned value, so
   // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
   assign w_mag_a   = (w_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
   assign w_mag_b   = (w_signed && b_i[31]) ? (32'd0 - b_i) : b_i;
   // Keep the divider well defined when b is zero; the result is discarded.
   assign w_divisor = (b_i == 32'd0) ? 32'd1 : w_mag_b;
   assign w_q_mag   = w_mag_a / w_divisor;
   assign w_r_mag   = w_mag_a % w_divisor;

   // Quotient truncates toward zero; remainder takes the dividend's sign.
   assign w_quot = (w_signed && (a_i[31] ^ b_i[31])) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem  = (w_signed && a_i[31]) ? (32'd0 - w_r_mag) : w_r_mag;

   assign res_hi_o = w_is_div ? w_rem  : w_prod[63:32];
   assign res_lo_o = w_is_div ? w_quot : w_prod[31:0];
   assign wr_en_o  = ~(w_is_div && (b_i == 32'd0));

endmodule : mdu_arith
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mdu_hilo                                                       |
// | Purpose : Multi-cycle multiply/divide unit with architectural HI/LO      |
// |           registers. The result is computed at launch and held pending; |
// |           it lands in HI/LO on the cycle busy falls.                     |
// | Ports   : clk            clock, rising edge                              |
// |           reset          asynchronous active-high reset                  |
// |           start          launch op (honoured only when idle)             |
// |           op     [1:0]   MULT / MULTU / DIV / DIVU                       |
// |           mthi, mtlo     write a into HI / LO (only when idle, no start) |
// |           a, b   [31:0]  rs / rt operands                                |
// |           busy           registered, high while an op is in flight       |
// |           stall_req      start | busy                                    |
// |           hi, lo [31:0]  HI / LO registers                               |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   // Counter only holds N-1, so clog2(N) bits suffice.
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   logic [0:0]       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [31:0]      pend_hi_q, pend_hi_d;
   logic [31:0]      pend_lo_q, pend_lo_d;
   logic             pend_wr_q, pend_wr_d;
   logic [31:0]      hi_q,      hi_d;
   logic [31:0]      lo_q,      lo_d;

   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             res_wr;

   mdu_arith u_arith (
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .res_hi_o (res_hi),
      .res_lo_o (res_lo),
      .wr_en_o  (res_wr)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Operands are captured here; a/b may change afterwards.
               pend_hi_d = res_hi;
               pend_lo_d = res_lo;
               pend_wr_d = res_wr;
               cnt_d     = op_is_div(op) ? DIV_LOAD : MULT_LOAD;
               state_d   = S_RUN;
            end else begin
               if (mthi) hi_d = a;
               if (mtlo) lo_d = a;
            end
         end
         S_RUN: begin
            // start/mthi/mtlo are ignored here; hazard logic stalls on stall_req.
            if (cnt_q == '0) begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy      = (state_q == S_RUN);
   assign stall_req = start | busy;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule : mdu_hilo
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mdu_hilo                                                    |
// | Purpose : Directed self-checking bench for mdu_hilo.                     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_mdu_hilo;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic        mthi;
   logic        mtlo;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   int tests_run    = 0;
   int tests_failed = 0;

   mdu_hilo #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .mthi      (mthi),
      .mtlo      (mtlo),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   // Stimulus only: called at posedge+1, launches an op, then counts the
   // cycles busy reads high (sampled 1 ns after each edge). Returns at
   // posedge+1 on the first cycle busy reads 0, or after a 64-cycle bound.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int cycles);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D;
      cycles = 0;
      while (busy === 1'b1 && cycles < 64) begin
         cycles++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 2'b00; mthi = 1'b0; mtlo = 1'b0;
      a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests_run++;
      if (hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi got %h exp 00000000", hi); end
      tests_run++;
      if (lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo got %h exp 00000000", lo); end
      tests_run++;
      if (stall_req !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b exp 0", stall_req); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      int cyc;
      run_op(2'b00, 32'hFFFF_FFFE, 32'd3, cyc);
      tests_run++;
      if (cyc != 5) begin tests_failed++; $display("FAIL mult_busy_cycles got %0d exp 5", cyc); end
      tests_run++;
      if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
      tests_run++;
      if (lo !== 32'hFFFF_FFFA) begin tests_failed++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
   endtask

   task automatic test_multu_div();
      int cyc;
      run_op(2'b01, 32'hFFFF_FFFF, 32'd2, cyc);
      tests_run++;
      if (cyc != 5) begin tests_failed++; $display("FAIL multu_busy_cycles got %0d exp 5", cyc); end
      tests_run++;
      if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
         tests_failed++; $display("FAIL multu_hilo got %h_%h exp 00000001_fffffffe", hi, lo);
      end
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
      tests_run++;
      if (cyc != 10) begin tests_failed++; $display("FAIL div_busy_cycles got %0d exp 10", cyc); end
      tests_run++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         tests_failed++; $display("FAIL div_neg_hilo got %h_%h exp ffffffff_fffffffd", hi, lo);
      end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      tests_run++;
      if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
         tests_failed++; $display("FAIL div_ovf_hilo got %h_%h exp 00000000_80000000", hi, lo);
      end
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, cyc);
      tests_run++;
      if (hi !== 32'h1 || lo !== 32'h7FFF_FFFC) begin
         tests_failed++; $display("FAIL divu_hilo got %h_%h exp 00000001_7ffffffc", hi, lo);
      end
      run_op(2'b00, 32'h0001_0000, 32'h0001_0000, cyc);
      tests_run++;
      if (hi !== 32'h1 || lo !== 32'h0) begin
         tests_failed++; $display("FAIL mult_carry_hilo got %h_%h exp 00000001_00000000", hi, lo);
      end
   endtask

   task automatic test_div_zero();
      int cyc;
      a = 32'h11; mthi = 1'b1;
      @(posedge clk); #1;
      mthi = 1'b0; a = 32'h22; mtlo = 1'b1;
      @(posedge clk); #1;
      mtlo = 1'b0;
      run_op(2'b11, 32'd7, 32'd0, cyc);
      tests_run++;
      if (cyc != 10) begin tests_failed++; $display("FAIL divz_busy_cycles got %0d exp 10", cyc); end
      tests_run++;
      if (hi !== 32'h11 || lo !== 32'h22) begin
         tests_failed++; $display("FAIL divz_hilo got %h_%h exp 00000011_00000022", hi, lo);
      end
   endtask

   task automatic test_ignore_busy();
      int cyc;
      start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
      #1;
      tests_run++;
      if (stall_req !== 1'b1) begin tests_failed++; $display("FAIL ign_stall_start got %b exp 1", stall_req); end
      @(posedge clk); #1;
      start = 1'b0; a = 32'h0; b = 32'h0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 64) begin
         cyc++;
         tests_run++;
         if (stall_req !== 1'b1) begin
            tests_failed++; $display("FAIL ign_stall_busy cycle %0d got %b exp 1", cyc, stall_req);
         end
         if (cyc == 2) begin
            start = 1'b1; op = 2'b10; mthi = 1'b1; a = 32'h55; b = 32'd1;
         end else begin
            start = 1'b0; mthi = 1'b0; op = 2'b00;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; mthi = 1'b0;
      tests_run++;
      if (cyc != 5) begin tests_failed++; $display("FAIL ign_busy_cycles got %0d exp 5", cyc); end
      tests_run++;
      if (hi !== 32'h0 || lo !== 32'd30) begin
         tests_failed++; $display("FAIL ign_hilo got %h_%h exp 00000000_0000001e", hi, lo);
      end
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL ign_no_relaunch got %b exp 0", busy); end
   endtask

   task automatic test_start_mtlo();
      int cyc;
      mtlo = 1'b1;
      run_op(2'b01, 32'd3, 32'd4, cyc);
      mtlo = 1'b0;
      tests_run++;
      if (cyc != 5) begin tests_failed++; $display("FAIL stmt_busy_cycles got %0d exp 5", cyc); end
      tests_run++;
      if (hi !== 32'h0 || lo !== 32'd12) begin
         tests_failed++; $display("FAIL stmt_hilo got %h_%h exp 00000000_0000000c", hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      mthi = 1'b1; a = 32'hABCD;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b1; a = 32'h1234;
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL mthi_busy got %b exp 0", busy); end
      @(posedge clk); #1;
      mtlo = 1'b0;
      tests_run++;
      if (hi !== 32'hABCD || lo !== 32'h1234) begin
         tests_failed++; $display("FAIL mthilo_hilo got %h_%h exp 0000abcd_00001234", hi, lo);
      end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL mtlo_busy got %b exp 0", busy); end
      mthi = 1'b1; mtlo = 1'b1; a = 32'h77;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      tests_run++;
      if (hi !== 32'h77 || lo !== 32'h77) begin
         tests_failed++; $display("FAIL mt_both_hilo got %h_%h exp 00000077_00000077", hi, lo);
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 4) begin
         cyc++;
         @(posedge clk); #1;
      end
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL arst_pre_busy got %b exp 1", busy); end
      #2 reset = 1'b1;
      #1;
      tests_run++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         tests_failed++; $display("FAIL arst_immediate got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         tests_failed++; $display("FAIL arst_after got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
      end
      run_op(2'b00, 32'd7, 32'd8, cyc);
      tests_run++;
      if (cyc != 5) begin tests_failed++; $display("FAIL arst_mult_cycles got %0d exp 5", cyc); end
      tests_run++;
      if (hi !== 32'h0 || lo !== 32'd56) begin
         tests_failed++; $display("FAIL arst_mult_hilo got %h_%h exp 00000000_00000038", hi, lo);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu_div();
      test_div_zero();
      test_ignore_busy();
      test_start_mtlo();
      test_mthi_mtlo();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_mdu_hilo
`default_nettype wire
